// File: rtl/calc_pkg.sv
// Shared definitions for the signed calculator datapath: default operand
// width, reconstructor state encoding and sign-magnitude field helpers.
package calc_pkg;

    localparam int unsigned CALC_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } recon_state_e;

    // Sign bit of a w-bit sign-magnitude value held in the low bits of x.
    function automatic logic sm_sign(input logic [31:0] x, input int unsigned w);
        logic [31:0] t;
        t = x >> (w - 32'd1);
        return t[0];
    endfunction

    // Magnitude field (bits w-2..0) of a w-bit sign-magnitude value.
    function automatic logic [31:0] sm_mag(input logic [31:0] x, input int unsigned w);
        return x & ((32'd1 << (w - 32'd1)) - 32'd1);
    endfunction

endpackage

// File: rtl/sm_reconstruct_if.sv
// Start/done handshake and operand/result bus of the dividend reconstructor.
interface sm_reconstruct_if #(
    parameter int unsigned W = calc_pkg::CALC_W
);
    logic             start;
    logic [W-1:0]     q;
    logic [W-1:0]     d;
    logic [W-1:0]     r;
    logic             busy;
    logic             done;
    logic [2*W-2:0]   dividend;
    logic             err;

    modport master (
        output start, q, d, r,
        input  busy, done, dividend, err
    );

    modport slave (
        input  start, q, d, r,
        output busy, done, dividend, err
    );
endinterface

// File: rtl/sm_recon_check.sv
// Combinational legality check of a (quotient, divisor, remainder) triple
// against truncating sign-magnitude division.
module sm_recon_check
    import calc_pkg::*;
#(
    parameter int unsigned W = CALC_W
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] d,
    input  logic [W-1:0] r,
    output logic         err_c
);
    localparam int unsigned MAG_W = W - 1;

    logic [MAG_W-1:0] qm, dm, rm;
    logic             qs, ds, rs;

    always_comb begin
        qm = MAG_W'(sm_mag(32'(q), W));
        dm = MAG_W'(sm_mag(32'(d), W));
        rm = MAG_W'(sm_mag(32'(r), W));
        qs = sm_sign(32'(q), W);
        ds = sm_sign(32'(d), W);
        rs = sm_sign(32'(r), W);
    end

    // Remainder must be smaller than the divisor and, when both are nonzero,
    // share the sign of the quotient*divisor product.
    always_comb begin
        err_c = 1'b0;
        if (dm == '0)
            err_c = 1'b1;
        else if (rm >= dm)
            err_c = 1'b1;
        else if ((qm != '0) && (rm != '0) && (rs != (qs ^ ds)))
            err_c = 1'b1;
    end
endmodule

// File: rtl/sm_reconstruct.sv
// Sequential sign-magnitude dividend reconstructor: dividend = q*d + r by
// shift-add. Define RECON_CHECK_EN to include the input legality check (err).
module sm_reconstruct
    import calc_pkg::*;
#(
    parameter int unsigned W = CALC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    sm_reconstruct_if.slave   bus
);
    localparam int unsigned MAG_W = W - 1;
    localparam int unsigned ACC_W = 2 * W - 2;
    localparam int unsigned CNT_W = (W > 2) ? $clog2(W) : 1;

    recon_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic [MAG_W-1:0] q_sh;
    logic [ACC_W-1:0] d_sh;
    logic [MAG_W-1:0] rm_r;
    logic [ACC_W-1:0] acc;
    logic             sign_r;
    logic             err_r;

    logic [MAG_W-1:0] qm_c, dm_c, rm_c;
    logic             sign_c;
    logic             err_c;
    logic [ACC_W-1:0] mag_c;

    // Operand decode and the result sign as it will stand before zero fixup.
    always_comb begin
        qm_c   = MAG_W'(sm_mag(32'(bus.q), W));
        dm_c   = MAG_W'(sm_mag(32'(bus.d), W));
        rm_c   = MAG_W'(sm_mag(32'(bus.r), W));
        sign_c = (qm_c != '0) ? (sm_sign(32'(bus.q), W) ^ sm_sign(32'(bus.d), W))
                              : sm_sign(32'(bus.r), W);
    end

`ifdef RECON_CHECK_EN
    sm_recon_check #(.W(W)) u_check (
        .q     (bus.q),
        .d     (bus.d),
        .r     (bus.r),
        .err_c (err_c)
    );
`else
    assign err_c = 1'b0;
`endif

    assign mag_c = acc + ACC_W'(rm_r);

    // Control FSM and datapath; q is consumed LSB first while d moves left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            q_sh         <= '0;
            d_sh         <= '0;
            rm_r         <= '0;
            acc          <= '0;
            sign_r       <= 1'b0;
            err_r        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.dividend <= '0;
            bus.err      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        q_sh     <= qm_c;
                        d_sh     <= ACC_W'(dm_c);
                        rm_r     <= rm_c;
                        sign_r   <= sign_c;
                        err_r    <= err_c;
                        acc      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    if (q_sh[0])
                        acc <= acc + d_sh;
                    q_sh <= q_sh >> 1;
                    d_sh <= d_sh << 1;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(W - 2))
                        state <= ADD;
                end
                ADD: begin
                    acc          <= mag_c;
                    bus.dividend <= {sign_r & (mag_c != '0), mag_c};
                    bus.err      <= err_r;
                    bus.done     <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sm_reconstruct.sv
// Randomized self-checking bench for sm_reconstruct against an arithmetic
// reference model of the sign-magnitude reconstruction rules.
module tb_sm_reconstruct;
    import calc_pkg::*;

    localparam int unsigned W  = CALC_W;
    localparam int unsigned DW = 2 * W - 1;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    sm_reconstruct_if #(.W(W)) bus ();

    sm_reconstruct #(.W(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: magnitudes multiply-add, sign from the quotient*divisor
    // product unless the quotient is zero, and zero is always positive.
    task automatic model(input logic [W-1:0] qi, input logic [W-1:0] di, input logic [W-1:0] ri,
                         output logic [DW-1:0] div_o, output logic err_o);
        int qm, dm, rm, qs, ds, rs, mag, sgn;
        int half;
        half = 1 << (W - 1);
        qm = int'(qi) % half;  qs = int'(qi) / half;
        dm = int'(di) % half;  ds = int'(di) / half;
        rm = int'(ri) % half;  rs = int'(ri) / half;
        mag = qm * dm + rm;
        sgn = (qm != 0) ? (qs ^ ds) : rs;
        if (mag == 0) sgn = 0;
        div_o = DW'(sgn * (1 << (DW - 1)) + mag);
`ifdef RECON_CHECK_EN
        err_o = (dm == 0) || (rm >= dm) || (qm != 0 && rm != 0 && rs != (qs ^ ds));
`else
        err_o = 1'b0;
`endif
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge
    // with the DUT idle again. mode 1: extra start in MUL; mode 2: reset in MUL.
    task automatic run_op(input logic [W-1:0] qi, input logic [W-1:0] di, input logic [W-1:0] ri,
                          input int mode);
        int            n;
        logic [DW-1:0] exp_div;
        logic          exp_err;
        model(qi, di, ri, exp_div, exp_err);
        bus.start = 1'b1;
        bus.q = qi;
        bus.d = di;
        bus.r = ri;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.q = W'($urandom);
        bus.d = W'($urandom);
        bus.r = W'($urandom);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        if (mode == 2) begin
            rst_n = 1'b0;
            #1;
            check("abort_busy", 32'(bus.busy), 32'd0);
            check("abort_done", 32'(bus.done), 32'd0);
            check("abort_dividend", 32'(bus.dividend), 32'd0);
            check("abort_err", 32'(bus.err), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (8) begin
                @(negedge clk);
                check("no_done_after_abort", 32'(bus.done), 32'd0);
            end
            return;
        end
        n = 1;
        while (!bus.done && n < 20) begin
            if (mode == 1 && n == 1) begin
                bus.start = 1'b1;
                bus.q = W'($urandom);
                bus.d = W'($urandom);
                bus.r = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check("latency", 32'(n), 32'(W + 1));
        check("dividend", 32'(bus.dividend), 32'(exp_div));
        check("err", 32'(bus.err), 32'(exp_err));
        check("busy_at_done", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_clear", 32'(bus.busy), 32'd0);
        check("dividend_hold", 32'(bus.dividend), 32'(exp_div));
        check("err_hold", 32'(bus.err), 32'(exp_err));
        if (mode == 1) begin
            repeat (6) begin
                @(negedge clk);
                check("no_second_done", 32'(bus.done), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.q = '0;
        bus.d = '0;
        bus.r = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dividend", 32'(bus.dividend), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'b001, 3'b010, 3'b001, 0);
        run_op(3'b101, 3'b010, 3'b101, 0);
        run_op(3'b011, 3'b111, 3'b000, 0);
        run_op(3'b011, 3'b011, 3'b010, 0);
        run_op(3'b000, 3'b011, 3'b110, 0);
        run_op(3'b100, 3'b111, 3'b100, 0);
        run_op(3'b010, 3'b000, 3'b001, 0);
        run_op(3'b001, 3'b010, 3'b010, 0);
        run_op(3'b001, 3'b010, 3'b101, 0);
        run_op(3'b011, 3'b010, 3'b001, 1);
        run_op(3'b011, 3'b011, 3'b001, 2);
        run_op(3'b010, 3'b011, 3'b001, 0);

        for (int i = 0; i < 120; i++) begin
            run_op(W'($urandom), W'($urandom), W'($urandom), ($urandom_range(0, 9) == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
